// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, control states and
// the shift-amount width helper.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLTU = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9,
      OP_MUL  = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   function automatic int SHAMT_W(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low DATA_WIDTH bits of the product.
// The first partial product is folded into the start cycle, so done rises DATA_WIDTH-1 edges later.
module alu_mul_iter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] product_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] mcand_q;
   logic [DATA_WIDTH-1:0] mplier_q;
   logic [DATA_WIDTH-1:0] acc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (start_i) begin
         cnt_q <= CNT_W'(DATA_WIDTH - 1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Datapath needs no reset: it is only observed once the counter has run down.
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         acc_q    <= b_i[0] ? a_i : '0;
         mcand_q  <= a_i << 1;
         mplier_q <= b_i >> 1;
      end else if (cnt_q != '0) begin
         acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end

   assign done_o    = (cnt_q == '0);
   assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU with an optional iterative multiplier.
// One result register stage; MUL parks the block in BUSY until the multiplier finishes.
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ALUCTRL_WIDTH = 4,
   parameter int MUL_EN        = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [ALUCTRL_WIDTH-1:0] ALUCtrl,
   input  logic [DATA_WIDTH-1:0]    ALUOP1,
   input  logic [DATA_WIDTH-1:0]    ALUOP2,
   output logic                     OutValid,
   input  logic                     OutReady,
   output logic [DATA_WIDTH-1:0]    SUM,
   output logic                     EQ,
   output logic                     ZERO,
   output logic                     ILLEGAL
);

   localparam int SHW = SHAMT_W(DATA_WIDTH);

   alu_state_e            state_q;
   logic [DATA_WIDTH-1:0] sum_q;
   logic                  eq_q;
   logic                  zero_q;
   logic                  ill_q;

   logic [DATA_WIDTH-1:0]        res_d;
   logic                         ill_d;
   logic                         is_mul;
   logic                         accept;
   logic                         mul_done;
   logic [DATA_WIDTH-1:0]        mul_prod;
   logic [SHW-1:0]               shamt;
   logic signed [DATA_WIDTH-1:0] op1_s;
   logic signed [DATA_WIDTH-1:0] op2_s;

   assign op1_s = $signed(ALUOP1);
   assign op2_s = $signed(ALUOP2);
   assign shamt = ALUOP2[SHW-1:0];

   assign InReady = (state_q == IDLE) | ((state_q == DONE) & OutReady);
   assign accept  = InValid & InReady;

   always_comb begin
      res_d  = '0;
      ill_d  = 1'b0;
      is_mul = 1'b0;
      case (ALUCtrl)
         ALUCTRL_WIDTH'(OP_ADD):  res_d = ALUOP1 + ALUOP2;
         ALUCTRL_WIDTH'(OP_SUB):  res_d = ALUOP1 - ALUOP2;
         ALUCTRL_WIDTH'(OP_AND):  res_d = ALUOP1 & ALUOP2;
         ALUCTRL_WIDTH'(OP_OR):   res_d = ALUOP1 | ALUOP2;
         ALUCTRL_WIDTH'(OP_XOR):  res_d = ALUOP1 ^ ALUOP2;
         ALUCTRL_WIDTH'(OP_SLT):  res_d = DATA_WIDTH'(op1_s < op2_s);
         ALUCTRL_WIDTH'(OP_SLTU): res_d = DATA_WIDTH'(ALUOP1 < ALUOP2);
         ALUCTRL_WIDTH'(OP_SLL):  res_d = ALUOP1 << shamt;
         ALUCTRL_WIDTH'(OP_SRL):  res_d = ALUOP1 >> shamt;
         ALUCTRL_WIDTH'(OP_SRA):  res_d = $unsigned(op1_s >>> shamt);
         ALUCTRL_WIDTH'(OP_MUL): begin
            if (MUL_EN != 0) begin
               is_mul = 1'b1;
            end else begin
               ill_d = 1'b1;
            end
         end
         default: ill_d = 1'b1;
      endcase
   end

   generate
      if (MUL_EN != 0) begin : g_mul
         logic mul_start;
         assign mul_start = accept & is_mul;

         alu_mul_iter #(
            .DATA_WIDTH(DATA_WIDTH)
         ) u_mul (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .start_i  (mul_start),
            .a_i      (ALUOP1),
            .b_i      (ALUOP2),
            .done_o   (mul_done),
            .product_o(mul_prod)
         );
      end else begin : g_nomul
         assign mul_done = 1'b1;
         assign mul_prod = '0;
      end
   endgenerate

   // Result registers only load on accept or multiplier completion, so they hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sum_q   <= '0;
         eq_q    <= 1'b0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  eq_q <= (ALUOP1 == ALUOP2);
                  if (is_mul) begin
                     state_q <= BUSY;
                  end else begin
                     state_q <= DONE;
                     sum_q   <= res_d;
                     zero_q  <= (res_d == '0);
                     ill_q   <= ill_d;
                  end
               end else if ((state_q == DONE) && OutReady) begin
                  state_q <= IDLE;
               end
            end
            BUSY: begin
               if (mul_done) begin
                  state_q <= DONE;
                  sum_q   <= mul_prod;
                  zero_q  <= (mul_prod == '0);
                  ill_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign OutValid = (state_q == DONE);
   assign SUM      = sum_q;
   assign EQ       = eq_q;
   assign ZERO     = zero_q;
   assign ILLEGAL  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (DATA_WIDTH=32): directed corner cases plus randomized traffic with
// random backpressure, checked by a queue-based scoreboard against an arithmetic model.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [3:0]  ALUCtrl = '0;
   logic [31:0] ALUOP1 = '0;
   logic [31:0] ALUOP2 = '0;
   logic        OutValid;
   logic        OutReady = 1'b1;
   logic [31:0] SUM;
   logic        EQ;
   logic        ZERO;
   logic        ILLEGAL;

   always #5 clk = ~clk;

   alu_seq #(
      .DATA_WIDTH(32),
      .ALUCTRL_WIDTH(4),
      .MUL_EN(1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .InValid (InValid),
      .InReady (InReady),
      .ALUCtrl (ALUCtrl),
      .ALUOP1  (ALUOP1),
      .ALUOP2  (ALUOP2),
      .OutValid(OutValid),
      .OutReady(OutReady),
      .SUM     (SUM),
      .EQ      (EQ),
      .ZERO    (ZERO),
      .ILLEGAL (ILLEGAL)
   );

   typedef struct {
      logic [31:0] sum;
      logic        eq;
      logic        zero;
      logic        ill;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   fresh = 1'b1;
   bit   bp_rand = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the opcode table, using plain arithmetic.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      int          s;
      s       = int'(b[4:0]);
      e.sum   = '0;
      e.ill   = 1'b0;
      e.lat   = 1;
      e.acc_cyc = 0;
      case (op)
         4'd0:  e.sum = a + b;
         4'd1:  e.sum = a - b;
         4'd2:  e.sum = a & b;
         4'd3:  e.sum = a | b;
         4'd4:  e.sum = a ^ b;
         4'd5:  e.sum = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         4'd6:  e.sum = {31'd0, (a < b)};
         4'd7:  e.sum = a << s;
         4'd8:  e.sum = a >> s;
         4'd9:  e.sum = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
         4'd10: begin
            p     = {32'd0, a} * {32'd0, b};
            e.sum = p[31:0];
            e.lat = 33;
         end
         default: e.ill = 1'b1;
      endcase
      e.eq   = (a == b);
      e.zero = (e.sum == 32'd0);
      return e;
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (bp_rand) begin
         #1;
         OutReady = ($urandom_range(0, 3) != 0);
      end
   end

   // Scoreboard push: one expected entry per handshake.
   always @(negedge clk) begin : recorder
      exp_t e;
      if (rst_n && InValid && InReady) begin
         e = model(ALUCtrl, ALUOP1, ALUOP2);
         e.acc_cyc = cyc;
         q.push_back(e);
      end
   end

   // Scoreboard pop: compare whenever the DUT presents a result.
   always @(negedge clk) begin : monitor
      if (rst_n && OutValid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got SUM=0x%0h, expected no result", SUM);
         end else begin
            if (fresh) begin
               chk("latency", 64'(cyc), 64'(q[0].acc_cyc + q[0].lat));
               fresh = 1'b0;
            end
            chk("result{SUM,EQ,ZERO,ILL}", {29'd0, SUM, EQ, ZERO, ILLEGAL},
                {29'd0, q[0].sum, q[0].eq, q[0].zero, q[0].ill});
            if (OutReady) begin
               q.delete(0);
               fresh = 1'b1;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge with InValid dropped.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      ALUCtrl = op;
      ALUOP1  = a;
      ALUOP2  = b;
      InValid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!InReady && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!InReady) begin
         n_vec++;
         n_bad++;
         $display("FAIL issue_timeout: InReady=%0b after %0d cycles, required 1", InReady, n);
      end
      @(posedge clk);
      #1;
      InValid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      InValid = 1'b0;
      #1;
      chk("rst_outvalid", 64'(OutValid), 64'd0);
      chk("rst_sum", 64'(SUM), 64'd0);
      chk("rst_illegal", 64'(ILLEGAL), 64'd0);
      q.delete();
      fresh = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("rst_inready", 64'(InReady), 64'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          busy;
      int          n;
      int          ov;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      #1;
      chk("init_outvalid", 64'(OutValid), 64'd0);
      chk("init_sum", 64'(SUM), 64'd0);
      chk("init_flags", {61'd0, EQ, ZERO, ILLEGAL}, 64'd0);
      #21;
      rst_n = 1'b1;
      #1;
      chk("init_inready", 64'(InReady), 64'd1);
      @(posedge clk);
      #1;

      issue(4'd0, 32'hFFFF_FFFF, 32'h1);
      chk("add_wrap_sum", 64'(SUM), 64'd0);
      chk("add_wrap_zero_valid", {62'd0, ZERO, OutValid}, 64'd3);
      issue(4'd1, 32'd5, 32'd7);
      chk("sub_sum", 64'(SUM), 64'hFFFF_FFFE);
      issue(4'd5, 32'hFFFF_FFFF, 32'h1);
      chk("slt_sum", 64'(SUM), 64'd1);
      issue(4'd6, 32'hFFFF_FFFF, 32'h1);
      chk("sltu_sum", 64'(SUM), 64'd0);
      issue(4'd9, 32'h8000_0000, 32'h21);
      chk("sra_sum", 64'(SUM), 64'hC000_0000);
      issue(4'd15, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      chk("illegal_flag_eq", {62'd0, ILLEGAL, EQ}, 64'd3);
      chk("illegal_sum", 64'(SUM), 64'd0);

      // MUL: count BUSY cycles with InReady low before the result shows up.
      issue(4'd10, 32'h1234, 32'h10);
      busy = 0;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (OutValid) break;
         if (!InReady) busy++;
      end
      chk("mul_busy_cycles", 64'(busy), 64'd32);
      chk("mul_sum", 64'(SUM), 64'h12340);
      @(posedge clk);
      #1;

      // Backpressure: result held, next op waits, then enters on the release edge.
      OutReady = 1'b0;
      issue(4'd0, 32'd2, 32'd3);
      ALUCtrl = 4'd1;
      ALUOP1  = 32'd9;
      ALUOP2  = 32'd2;
      InValid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_inready", 64'(InReady), 64'd0);
         chk("bp_sum_held", {31'd0, OutValid, SUM}, {31'd0, 1'b1, 32'd5});
      end
      @(posedge clk);
      #1;
      OutReady = 1'b1;
      @(negedge clk);
      chk("bp_release_inready", 64'(InReady), 64'd1);
      @(posedge clk);
      #1;
      InValid = 1'b0;
      @(negedge clk);
      chk("bp_next_sum", {31'd0, OutValid, SUM}, {31'd0, 1'b1, 32'd7});
      @(posedge clk);
      #1;

      // Reset with a held result, then reset in the middle of a multiply.
      OutReady = 1'b0;
      issue(4'd4, 32'h0F0F, 32'h00FF);
      do_reset();
      OutReady = 1'b1;
      issue(4'd10, 32'd7, 32'd9);
      repeat (9) @(posedge clk);
      do_reset();
      ov = 0;
      repeat (40) begin
         @(negedge clk);
         if (OutValid) ov++;
      end
      chk("mul_abort_no_output", 64'(ov), 64'd0);
      @(posedge clk);
      #1;

      // Randomized traffic with random backpressure.
      bp_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = rnd_val();
         b  = ($urandom_range(0, 7) == 0) ? a : rnd_val();
         issue(op, a, b);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      bp_rand = 1'b0;
      @(posedge clk);
      #2;
      OutReady = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
